// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register: single entry (SKID=0) or 2-entry skid with registered in_ready (SKID=1).
// Optional saturating stall counter enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SKID   = 0,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    logic              in_fire_s;
    logic              out_fire_s;
    logic              out_valid_s;
    logic [DATA_W-1:0] main_r;

    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid_s & out_ready;
    assign out_valid  = out_valid_s;
    assign out_data   = main_r;

    generate
        if (SKID == 32'd0) begin : g_single
            logic              valid_r;
            logic              valid_nxt_s;
            logic [DATA_W-1:0] main_nxt_s;

            // Next-state for the single entry; a new payload overrides a same-cycle drain.
            always_comb begin
                valid_nxt_s = valid_r;
                main_nxt_s  = main_r;
                if (flush) begin
                    valid_nxt_s = 1'b0;
                end else if (in_fire_s) begin
                    valid_nxt_s = 1'b1;
                    main_nxt_s  = in_data;
                end else if (out_fire_s) begin
                    valid_nxt_s = 1'b0;
                end else begin
                    valid_nxt_s = valid_r;
                end
            end

            // Single-entry state and payload registers.
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_r <= 1'b0;
                    main_r  <= {DATA_W{1'b0}};
                end else begin
                    valid_r <= valid_nxt_s;
                    main_r  <= main_nxt_s;
                end
            end

            assign in_ready    = ~valid_r | out_ready;
            assign out_valid_s = valid_r;
            assign occ         = {1'b0, valid_r};
        end else begin : g_skid
            state_t            state_r;
            state_t            state_nxt_s;
            logic [DATA_W-1:0] skid_r;
            logic [DATA_W-1:0] skid_nxt_s;
            logic [DATA_W-1:0] main_nxt_s;
            logic              in_ready_r;

            // Skid FSM: main always holds the oldest payload, skid the younger one.
            always_comb begin
                state_nxt_s = state_r;
                main_nxt_s  = main_r;
                skid_nxt_s  = skid_r;
                if (flush) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    case (state_r)
                        ST_EMPTY: begin
                            if (in_fire_s) begin
                                state_nxt_s = ST_ONE;
                                main_nxt_s  = in_data;
                            end else begin
                                state_nxt_s = ST_EMPTY;
                            end
                        end
                        ST_ONE: begin
                            if (in_fire_s && out_fire_s) begin
                                main_nxt_s = in_data;
                            end else if (in_fire_s) begin
                                state_nxt_s = ST_FULL;
                                skid_nxt_s  = in_data;
                            end else if (out_fire_s) begin
                                state_nxt_s = ST_EMPTY;
                            end else begin
                                state_nxt_s = ST_ONE;
                            end
                        end
                        ST_FULL: begin
                            if (out_fire_s) begin
                                state_nxt_s = ST_ONE;
                                main_nxt_s  = skid_r;
                            end else begin
                                state_nxt_s = ST_FULL;
                            end
                        end
                        default: begin
                            state_nxt_s = ST_EMPTY;
                        end
                    endcase
                end
            end

            // State, payload and registered in_ready (derived from next state).
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_r    <= ST_EMPTY;
                    main_r     <= {DATA_W{1'b0}};
                    skid_r     <= {DATA_W{1'b0}};
                    in_ready_r <= 1'b1;
                end else begin
                    state_r    <= state_nxt_s;
                    main_r     <= main_nxt_s;
                    skid_r     <= skid_nxt_s;
                    in_ready_r <= (state_nxt_s != ST_FULL);
                end
            end

            assign in_ready    = in_ready_r;
            assign out_valid_s = (state_r != ST_EMPTY);
            assign occ         = state_r;
        end
    endgenerate

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;

    // Saturating count of cycles where a payload waits on downstream; flush does not clear it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (out_valid_s && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    // CNT_W only sizes the optional stall counter.
    if (CNT_W == 32'd0) begin : g_cnt_w_unused
    end
`endif

endmodule
